// File: rtl/mdu_iterative_if.sv
// Handshake/operand bundle between the multicycle controller and the
// iterative multiply/divide unit.
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, result, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, illegal
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit implementing the RV32M op set.
// One shift-add (multiply) or restoring (divide) step per clock.
// Build option: define MDU_DIV_EN to include the divider datapath; without it,
// div/rem ops complete one edge after accept with result 0 and illegal high.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH iteration steps
// FIX   | sign correction, special cases, result select
// DONE  | done pulse, result valid
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mdu_iterative_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opa_q;      // multiplier (shifts right) or dividend (shifts left)
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q;      // product, or {remainder, quotient}
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic [WIDTH-1:0]   result_q;

    logic               a_signed;
    logic               b_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_val;

`ifdef MDU_DIV_EN
    logic               sign_a_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic               bzero_q;
    logic               ovf_q;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
`else
    logic               illegal_q;
`endif

    // Operand signedness and magnitudes decoded from the incoming request
    always_comb begin
        a_signed = (bus.op == 3'b000) || (bus.op == 3'b001) || (bus.op == 3'b010) ||
                   (bus.op == 3'b100) || (bus.op == 3'b110);
        b_signed = (bus.op == 3'b000) || (bus.op == 3'b001) ||
                   (bus.op == 3'b100) || (bus.op == 3'b110);
        a_neg    = a_signed && bus.a[WIDTH-1];
        b_neg    = b_signed && bus.b[WIDTH-1];
        a_mag    = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_mag    = b_neg ? (~bus.b + 1'b1) : bus.b;
    end

    // One shift-add multiply step: conditionally add multiplicand, shift right
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opa_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef MDU_DIV_EN
    // One restoring divide step: shift in next dividend bit, trial subtract
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift - {1'b0, opb_q};
        div_next  = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
`endif

    // Sign fix-up, special-case override and result selection
    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
`ifdef MDU_DIV_EN
        quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
`endif
        fix_val  = '0;
        case (op_q)
            3'b000:                 fix_val = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
`ifdef MDU_DIV_EN
            3'b100, 3'b101: begin
                if (bzero_q)    fix_val = '1;
                else if (ovf_q) fix_val = a_raw_q;
                else            fix_val = quo_fix;
            end
            3'b110, 3'b111: begin
                if (bzero_q)    fix_val = a_raw_q;
                else if (ovf_q) fix_val = '0;
                else            fix_val = rem_fix;
            end
`endif
            default:                fix_val = '0;
        endcase
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
`ifdef MDU_DIV_EN
            sign_a_q <= 1'b0;
            a_raw_q  <= '0;
            bzero_q  <= 1'b0;
            ovf_q    <= 1'b0;
`else
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        opa_q <= a_mag;
                        opb_q <= b_mag;
                        acc_q <= '0;
                        cnt_q <= '0;
                        neg_q <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        sign_a_q <= a_neg;
                        a_raw_q  <= bus.a;
                        bzero_q  <= bus.op[2] && (bus.b == '0);
                        ovf_q    <= bus.op[2] && !bus.op[0] &&
                                    (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
                        state_q  <= S_CALC;
`else
                        if (bus.op[2]) begin
                            result_q  <= '0;
                            illegal_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            state_q   <= S_CALC;
                        end
`endif
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
`ifdef MDU_DIV_EN
                    if (op_q[2]) begin
                        acc_q <= div_next;
                        opa_q <= opa_q << 1;
                    end else begin
                        acc_q <= mul_next;
                        opa_q <= opa_q >> 1;
                    end
`else
                    acc_q <= mul_next;
                    opa_q <= opa_q >> 1;
`endif
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_val;
                    state_q  <= S_DONE;
                end
                default: begin
`ifndef MDU_DIV_EN
                    illegal_q <= 1'b0;
`endif
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
`ifdef MDU_DIV_EN
    assign bus.illegal = 1'b0;
`else
    assign bus.illegal = illegal_q;
`endif

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative at WIDTH=32.
// Divide checks follow MDU_DIV_EN; without it the compiled-out behaviour is checked.
module tb_mdu_iterative;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mdu_iterative_if #(.WIDTH(32)) bus ();

    mdu_iterative #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op (called at #1 after an edge with the unit idle); returns the
    // number of edges from accept until done was seen, or -1 on timeout.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic il, output int lat);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        r   = '0;
        il  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                lat = i;
                r   = bus.result;
                il  = bus.illegal;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
        n_checks++;
        if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
        n_checks++;
        if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %0b want 0", bus.illegal); end
        bus.start = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [31:0] r;
        logic        il;
        int          lat;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd7;
        bus.b     = 32'hFFFFFFFD;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_after_accept got %0b want 1", bus.busy); end
        lat = -1;
        r   = '0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin lat = i; r = bus.result; break; end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got %0d want 33", lat); end
        n_checks++;
        if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", r); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul_done_one_cycle got %0b want 0", bus.done); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_fall got %0b want 0", bus.busy); end
        n_checks++;
        if (bus.result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result_hold got %h want ffffffeb", bus.result); end
        run_op(3'b000, 32'd6, 32'd7, r, il, lat);
        n_checks++;
        if (r !== 32'd42 || il !== 1'b0 || lat !== 33) begin
            n_fail++; $display("FAIL mul_6x7 got r=%h il=%0b lat=%0d want 2a 0 33", r, il, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mulh();
        logic [31:0] r;
        logic        il;
        int          lat;
        run_op(3'b001, 32'h80000000, 32'h80000000, r, il, lat);
        n_checks++;
        if (r !== 32'h40000000 || lat !== 33) begin n_fail++; $display("FAIL mulh got r=%h lat=%0d want 40000000 33", r, lat); end
        @(posedge clk); #1;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, il, lat);
        n_checks++;
        if (r !== 32'hFFFFFFFE || lat !== 33) begin n_fail++; $display("FAIL mulhu got r=%h lat=%0d want fffffffe 33", r, lat); end
        @(posedge clk); #1;
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, r, il, lat);
        n_checks++;
        if (r !== 32'hFFFFFFFF || lat !== 33) begin n_fail++; $display("FAIL mulhsu got r=%h lat=%0d want ffffffff 33", r, lat); end
        @(posedge clk); #1;
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        logic [2:0]  ops  [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bs   [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] exps [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        logic [31:0] r;
        logic        il;
        int          lat;
        for (int k = 0; k < 6; k++) begin
            run_op(ops[k], as[k], bs[k], r, il, lat);
            n_checks++;
            if (r !== exps[k] || il !== 1'b0 || lat !== 33) begin
                n_fail++;
                $display("FAIL div_vec%0d got r=%h il=%0b lat=%0d want %h 0 33", k, r, il, lat, exps[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops  [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as   [6] = '{32'd5, 32'd5, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'h80000000, 32'h80000000};
        logic [31:0] bs   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h80000000, 32'd0};
        logic [31:0] r;
        logic        il;
        int          lat;
        for (int k = 0; k < 6; k++) begin
            run_op(ops[k], as[k], bs[k], r, il, lat);
            n_checks++;
            if (r !== exps[k] || lat !== 33) begin
                n_fail++;
                $display("FAIL special_vec%0d got r=%h lat=%0d want %h 33", k, r, lat, exps[k]);
            end
            @(posedge clk); #1;
        end
    endtask
`else
    task automatic test_nodiv();
        logic [31:0] r;
        logic        il;
        int          lat;
        run_op(3'b101, 32'd100, 32'd7, r, il, lat);
        n_checks++;
        if (lat !== 0) begin n_fail++; $display("FAIL nodiv_latency got %0d edges want 1", lat + 1); end
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL nodiv_result got %h want 0", r); end
        n_checks++;
        if (il !== 1'b1) begin n_fail++; $display("FAIL nodiv_illegal got %0b want 1", il); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL nodiv_after got done=%0b busy=%0b illegal=%0b want 0 0 0", bus.done, bus.busy, bus.illegal);
        end
        run_op(3'b110, 32'd9, 32'd4, r, il, lat);
        n_checks++;
        if (lat !== 0 || r !== 32'd0 || il !== 1'b1) begin
            n_fail++; $display("FAIL nodiv_rem got r=%h il=%0b lat=%0d want 0 1 0", r, il, lat);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_busy_ignore();
        logic [31:0] r;
        int          lat;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd7;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.a     = 32'd100;
        bus.b     = 32'd100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        r   = '0;
        for (int i = 6; i < 100; i++) begin
            if (bus.done) begin lat = i; r = bus.result; break; end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (r !== 32'd21 || lat !== 33) begin n_fail++; $display("FAIL busy_ignore got r=%h lat=%0d want 15 33", r, lat); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_not_queued got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        logic        il;
        int          lat;
        int          seen;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'h1234;
        bus.b     = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_state got busy=%0b done=%0b result=%h want 0 0 0", bus.busy, bus.done, bus.result);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d done cycles want 0", seen); end
        run_op(3'b000, 32'd3, 32'd4, r, il, lat);
        n_checks++;
        if (r !== 32'd12 || lat !== 33) begin n_fail++; $display("FAIL abort_fresh_mul got r=%h lat=%0d want c 33", r, lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_mul();
        test_mulh();
`ifdef MDU_DIV_EN
        test_div();
        test_special();
`else
        test_nodiv();
`endif
        test_busy_ignore();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
